// File: rtl/usb_key_injector.sv
// Keystroke injector: CPU-fed ASCII FIFO replayed as HID keyboard
// press/release reports for paste, autotype and self-test.
module usb_key_injector #(
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 400000,
    parameter int GAP_CYCLES  = 400000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_n,
    input  logic       usb_cs,
    input  logic [7:0] reg_addr_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic [1:0] typ,
    output logic       report,
    output logic [7:0] key_modifiers,
    output logic [7:0] key1,
    output logic [7:0] key2
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int HOLD_LD = (HOLD_CYCLES > 1) ? HOLD_CYCLES - 2 : 0;
    localparam int GAP_LD  = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;
    localparam logic HOLD_SHORT = (HOLD_CYCLES <= 1);
    localparam logic GAP_SHORT  = (GAP_CYCLES <= 1);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_PRESS, S_HOLD, S_RELEASE, S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      char_q, char_d;
    logic [7:0]      key1_q, key1_d;
    logic [7:0]      mod_q, mod_d;
    logic            report_q, report_d;
    logic [1:0]      typ_q, typ_d;
    logic            ovf_q, ovf_d;
    logic            bad_q, bad_d;
    logic            wr_prev_q, wr_prev_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [7:0]      mem_q [DEPTH];

    logic            wr_act, wr_pulse;
    logic [PW-1:0]   count;
    logic            empty, full, busy;
    logic            push_req, push, pop, flush;
    logic [16:0]     enc;

    // Returns {mappable, modifiers, scancode}
    function automatic logic [16:0] encode(input logic [7:0] c);
        logic       v;
        logic [7:0] m, k;
        v = 1'b0;
        m = 8'h00;
        k = 8'h00;
        if (c >= 8'h61 && c <= 8'h7A) begin
            v = 1'b1; k = c - 8'h5D;
        end else if (c >= 8'h41 && c <= 8'h5A) begin
            v = 1'b1; m = 8'h02; k = c - 8'h3D;
        end else if (c >= 8'h01 && c <= 8'h1A) begin
            v = 1'b1; m = 8'h01; k = c + 8'h03;
        end else if (c >= 8'h31 && c <= 8'h39) begin
            v = 1'b1; k = c - 8'h13;
        end
        case (c)
            8'h0D: begin v = 1'b1; m = 8'h00; k = 8'h28; end
            8'h08: begin v = 1'b1; m = 8'h00; k = 8'h2A; end
            8'h09: begin v = 1'b1; m = 8'h00; k = 8'h2B; end
            8'h1B: begin v = 1'b1; k = 8'h29; end
            8'h20: begin v = 1'b1; k = 8'h2C; end
            8'h30: begin v = 1'b1; k = 8'h27; end
            8'h2D: begin v = 1'b1; k = 8'h2D; end
            8'h3D: begin v = 1'b1; k = 8'h2E; end
            8'h5B: begin v = 1'b1; k = 8'h2F; end
            8'h5D: begin v = 1'b1; k = 8'h30; end
            8'h5C: begin v = 1'b1; k = 8'h31; end
            8'h23: begin v = 1'b1; k = 8'h32; end
            8'h3B: begin v = 1'b1; k = 8'h33; end
            8'h27: begin v = 1'b1; k = 8'h34; end
            8'h60: begin v = 1'b1; k = 8'h35; end
            8'h2C: begin v = 1'b1; k = 8'h36; end
            8'h2E: begin v = 1'b1; k = 8'h37; end
            8'h2F: begin v = 1'b1; k = 8'h38; end
            8'h21: begin v = 1'b1; m = 8'h02; k = 8'h1E; end
            8'h40: begin v = 1'b1; m = 8'h02; k = 8'h1F; end
            8'h24: begin v = 1'b1; m = 8'h02; k = 8'h21; end
            8'h25: begin v = 1'b1; m = 8'h02; k = 8'h22; end
            8'h5E: begin v = 1'b1; m = 8'h02; k = 8'h23; end
            8'h26: begin v = 1'b1; m = 8'h02; k = 8'h24; end
            8'h2A: begin v = 1'b1; m = 8'h02; k = 8'h25; end
            8'h28: begin v = 1'b1; m = 8'h02; k = 8'h26; end
            8'h29: begin v = 1'b1; m = 8'h02; k = 8'h27; end
            8'h5F: begin v = 1'b1; m = 8'h02; k = 8'h2D; end
            8'h2B: begin v = 1'b1; m = 8'h02; k = 8'h2E; end
            8'h7B: begin v = 1'b1; m = 8'h02; k = 8'h2F; end
            8'h7D: begin v = 1'b1; m = 8'h02; k = 8'h30; end
            8'h7C: begin v = 1'b1; m = 8'h02; k = 8'h31; end
            8'h7E: begin v = 1'b1; m = 8'h02; k = 8'h35; end
            8'h3A: begin v = 1'b1; m = 8'h02; k = 8'h33; end
            8'h22: begin v = 1'b1; m = 8'h02; k = 8'h34; end
            8'h3C: begin v = 1'b1; m = 8'h02; k = 8'h36; end
            8'h3E: begin v = 1'b1; m = 8'h02; k = 8'h37; end
            8'h3F: begin v = 1'b1; m = 8'h02; k = 8'h38; end
            8'h89: begin v = 1'b1; k = 8'h4F; end
            8'h88: begin v = 1'b1; k = 8'h50; end
            8'h8A: begin v = 1'b1; k = 8'h51; end
            8'h8B: begin v = 1'b1; k = 8'h52; end
            default: ;
        endcase
        return {v, m, k};
    endfunction

    always_comb begin
        wr_act    = usb_cs & ~wr_n;
        wr_pulse  = wr_act & ~wr_prev_q;
        wr_prev_d = wr_act;
        count     = wptr_q - rptr_q;
        empty     = (count == '0);
        full      = (count == DEPTH_P);
        busy      = (state_q != S_IDLE);
        push_req  = wr_pulse && (reg_addr_i == 8'h00);
        push      = push_req && !full;
        flush     = wr_pulse && (reg_addr_i == 8'h03);
        pop       = (state_q == S_IDLE) && !empty;
        enc       = encode(char_q);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        char_d   = char_q;
        key1_d   = key1_q;
        mod_d    = mod_q;
        report_d = 1'b0;
        typ_d    = 2'd1;
        ovf_d    = ovf_q;
        bad_d    = bad_q;
        wptr_d   = flush ? '0 : wptr_q + PW'(push);
        rptr_d   = flush ? '0 : rptr_q + PW'(pop);
        if (wr_pulse && reg_addr_i == 8'h02) begin
            if (data_i[0]) ovf_d = 1'b0;
            if (data_i[1]) bad_d = 1'b0;
        end
        if (push_req && full) ovf_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    char_d  = mem_q[rptr_q[AW-1:0]];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (enc[16]) begin
                    mod_d    = enc[15:8];
                    key1_d   = enc[7:0];
                    report_d = 1'b1;
                    state_d  = S_PRESS;
                end else begin
                    bad_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_PRESS: begin
                if (HOLD_SHORT) begin
                    key1_d   = 8'h00;
                    mod_d    = 8'h00;
                    report_d = 1'b1;
                    state_d  = S_RELEASE;
                end else begin
                    cnt_d   = CW'(HOLD_LD);
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    key1_d   = 8'h00;
                    mod_d    = 8'h00;
                    report_d = 1'b1;
                    state_d  = S_RELEASE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RELEASE: begin
                if (GAP_SHORT) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = CW'(GAP_LD);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            char_q    <= 8'h00;
            key1_q    <= 8'h00;
            mod_q     <= 8'h00;
            report_q  <= 1'b0;
            typ_q     <= 2'd0;
            ovf_q     <= 1'b0;
            bad_q     <= 1'b0;
            wr_prev_q <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            char_q    <= char_d;
            key1_q    <= key1_d;
            mod_q     <= mod_d;
            report_q  <= report_d;
            typ_q     <= typ_d;
            ovf_q     <= ovf_d;
            bad_q     <= bad_d;
            wr_prev_q <= wr_prev_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

    always_comb begin
        data_o = 8'h00;
        case (reg_addr_i)
            8'h00:   data_o = {4'b0, busy, ovf_q, full, empty};
            8'h01:   data_o = 8'(DEPTH_P - count);
            8'h02:   data_o = {7'b0, bad_q};
            default: data_o = 8'h00;
        endcase
    end

    assign typ           = typ_q;
    assign report        = report_q;
    assign key_modifiers = mod_q;
    assign key1          = key1_q;
    assign key2          = 8'h00;
endmodule

// File: tb/tb_usb_key_injector.sv
// Directed bench for usb_key_injector: encoding table, report timing,
// FIFO overflow/flush, write edge detect and mid-character reset.
module tb_usb_key_injector;
    localparam int DEPTH = 4;
    localparam int HOLD  = 40;
    localparam int GAP   = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_n = 1'b1;
    logic       usb_cs = 1'b0;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_o;
    logic [1:0] typ;
    logic       report;
    logic [7:0] key_modifiers, key1, key2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rpt_cnt = 0;
    int rq_cyc[$];
    logic [7:0] rq_key[$];
    logic [7:0] rq_mod[$];

    usb_key_injector #(
        .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
    ) dut (
        .clk_i(clk), .rst_i(rst), .wr_n(wr_n), .usb_cs(usb_cs),
        .reg_addr_i(reg_addr), .data_i(data_in), .data_o(data_o),
        .typ(typ), .report(report), .key_modifiers(key_modifiers),
        .key1(key1), .key2(key2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (report) begin
            rpt_cnt++;
            rq_cyc.push_back(cyc);
            rq_key.push_back(key1);
            rq_mod.push_back(key_modifiers);
        end
        cyc++;
    end

    typedef struct {
        logic [7:0] ch;
        logic       ok;
        logic [7:0] mod;
        logic [7:0] key;
    } vec_t;
    vec_t vt[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input int n);
        @(posedge clk); #1;
        reg_addr = a; data_in = d; usb_cs = 1'b1; wr_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        usb_cs = 1'b0; wr_n = 1'b1;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        @(posedge clk); #1;
        reg_addr = a;
        #1;
        v = data_o;
    endtask

    task automatic wait_rpt(input int budget, output int at, output logic ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (report) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            reg_addr = 8'h00;
            #1;
            if (!data_o[3]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] v;
        logic ok;
        int w, p, r, n0;

        vt[0]  = '{8'h61, 1'b1, 8'h00, 8'h04};
        vt[1]  = '{8'h41, 1'b1, 8'h02, 8'h04};
        vt[2]  = '{8'h23, 1'b1, 8'h00, 8'h32};
        vt[3]  = '{8'h03, 1'b1, 8'h01, 8'h06};
        vt[4]  = '{8'h7A, 1'b1, 8'h00, 8'h1D};
        vt[5]  = '{8'h30, 1'b1, 8'h00, 8'h27};
        vt[6]  = '{8'h39, 1'b1, 8'h00, 8'h26};
        vt[7]  = '{8'h0D, 1'b1, 8'h00, 8'h28};
        vt[8]  = '{8'h08, 1'b1, 8'h00, 8'h2A};
        vt[9]  = '{8'h20, 1'b1, 8'h00, 8'h2C};
        vt[10] = '{8'h7E, 1'b1, 8'h02, 8'h35};
        vt[11] = '{8'h3F, 1'b1, 8'h02, 8'h38};
        vt[12] = '{8'h89, 1'b1, 8'h00, 8'h4F};
        vt[13] = '{8'h8B, 1'b1, 8'h00, 8'h52};
        vt[14] = '{8'h1A, 1'b1, 8'h01, 8'h1D};
        vt[15] = '{8'h1B, 1'b1, 8'h00, 8'h29};
        vt[16] = '{8'h80, 1'b0, 8'h00, 8'h00};
        vt[17] = '{8'h7F, 1'b0, 8'h00, 8'h00};

        #2;
        chk("rst_report", 32'(report), 32'd0);
        chk("rst_key1", 32'(key1), 32'd0);
        chk("rst_mod", 32'(key_modifiers), 32'd0);
        chk("rst_typ", 32'(typ), 32'd0);
        reg_addr = 8'h00; #1;
        chk("rst_status", 32'(data_o), 32'h01);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(8'h01, v);
        chk("free_after_rst", 32'(v), 32'd4);
        chk("typ_kbd", 32'(typ), 32'd1);
        chk("key2_zero", 32'(key2), 32'd0);

        for (int i = 0; i < 18; i++) begin
            if (vt[i].ok) begin
                wr(8'h00, vt[i].ch, 1);
                w = cyc;
                wait_rpt(8, p, ok);
                chk($sformatf("press_seen[%0d]", i), 32'(ok), 32'd1);
                chk($sformatf("press_lat[%0d]", i), 32'(p - w), 32'd2);
                chk($sformatf("press_mod[%0d]", i), 32'(key_modifiers), 32'(vt[i].mod));
                chk($sformatf("press_key[%0d]", i), 32'(key1), 32'(vt[i].key));
                wait_rpt(HOLD + 4, r, ok);
                chk($sformatf("rel_seen[%0d]", i), 32'(ok), 32'd1);
                chk($sformatf("hold_time[%0d]", i), 32'(r - p), 32'(HOLD));
                chk($sformatf("rel_keys[%0d]", i), 32'({key_modifiers, key1}), 32'd0);
                wait_idle(GAP + 6, ok);
                chk($sformatf("idle[%0d]", i), 32'(ok), 32'd1);
            end else begin
                n0 = rpt_cnt;
                wr(8'h00, vt[i].ch, 1);
                wait_idle(3, ok);
                chk($sformatf("bad_idle[%0d]", i), 32'(ok), 32'd1);
                repeat (4) @(posedge clk);
                chk($sformatf("bad_no_rpt[%0d]", i), 32'(rpt_cnt - n0), 32'd0);
                rd(8'h02, v);
                chk($sformatf("bad_flag[%0d]", i), 32'(v), 32'd1);
                wr(8'h02, 8'h02, 1);
                rd(8'h02, v);
                chk($sformatf("bad_clr[%0d]", i), 32'(v), 32'd0);
            end
        end

        // Repeated character: two press/release pairs with the gap between.
        rq_cyc.delete(); rq_key.delete(); rq_mod.delete();
        wr(8'h00, 8'h78, 1);
        wr(8'h00, 8'h78, 1);
        repeat (2 * HOLD + GAP + 20) @(posedge clk);
        chk("xx_count", 32'(rq_cyc.size()), 32'd4);
        if (rq_cyc.size() == 4) begin
            chk("xx_k0", 32'({rq_mod[0], rq_key[0]}), 32'h001B);
            chk("xx_k1", 32'({rq_mod[1], rq_key[1]}), 32'h0000);
            chk("xx_k2", 32'({rq_mod[2], rq_key[2]}), 32'h001B);
            chk("xx_k3", 32'({rq_mod[3], rq_key[3]}), 32'h0000);
            chk("xx_hold1", 32'(rq_cyc[1] - rq_cyc[0]), 32'(HOLD));
            chk("xx_gap", 32'(rq_cyc[2] - rq_cyc[1]), 32'(GAP + 2));
            chk("xx_hold2", 32'(rq_cyc[3] - rq_cyc[2]), 32'(HOLD));
        end

        // Overflow while busy, OVF clear, then flush mid-character.
        wr(8'h00, 8'h61, 1);
        wait_rpt(8, p, ok);
        chk("ovf_press", 32'(ok), 32'd1);
        for (int k = 0; k < DEPTH + 1; k++) wr(8'h00, 8'(8'h62 + k), 1);
        rd(8'h00, v);
        chk("ovf_status", 32'(v), 32'h0E);
        rd(8'h01, v);
        chk("ovf_free", 32'(v), 32'd0);
        wr(8'h02, 8'h01, 1);
        rd(8'h00, v);
        chk("ovf_clr", 32'(v), 32'h0A);
        wr(8'h03, 8'h00, 1);
        rd(8'h00, v);
        chk("flush_status", 32'(v), 32'h09);
        rd(8'h01, v);
        chk("flush_free", 32'(v), 32'd4);
        n0 = rpt_cnt;
        wait_rpt(HOLD + 4, r, ok);
        chk("flush_release", 32'(ok), 32'd1);
        chk("flush_rel_key", 32'(key1), 32'd0);
        repeat (GAP + 10) @(posedge clk);
        chk("flush_no_more", 32'(rpt_cnt - n0), 32'd1);

        // Multi-cycle write: exactly one push.
        n0 = rpt_cnt;
        wr(8'h00, 8'h62, 3);
        repeat (HOLD + GAP + 15) @(posedge clk);
        chk("long_wr_rpts", 32'(rpt_cnt - n0), 32'd2);
        rd(8'h00, v);
        chk("long_wr_status", 32'(v), 32'h01);

        // Reset during HOLD.
        wr(8'h00, 8'h7A, 1);
        wait_rpt(8, p, ok);
        chk("rst_hold_press", 32'(key1), 32'h1D);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rsth_report", 32'(report), 32'd0);
        chk("rsth_key1", 32'(key1), 32'd0);
        chk("rsth_typ", 32'(typ), 32'd0);
        reg_addr = 8'h00; #1;
        chk("rsth_status", 32'(data_o), 32'h01);
        n0 = rpt_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (HOLD + 5) @(posedge clk);
        chk("rsth_no_release", 32'(rpt_cnt - n0), 32'd0);
        rd(8'h01, v);
        chk("rsth_free", 32'(v), 32'd4);
        chk("rsth_typ_back", 32'(typ), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
